// File: rtl/clock_div_pkg.sv
// Shared types and sizing helpers for the clock divider bank.
package clock_div_pkg;

  localparam int unsigned DIV_W_DEF = 28;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] duty;
  } div_cfg_t;

  // Select width for a channel index, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: active/shadow config, period counter, registered clk_out/tick.
module clock_divider_channel
  import clock_div_pkg::*;
(
  input  logic     clock_in,
  input  logic     reset_n,
  input  logic     en,
  input  logic     sync,
  input  logic     wr,
  input  div_cfg_t wr_cfg,
  output logic     clk_out,
  output logic     tick,
  output logic     pending
);

  div_cfg_t             act_q, act_d;
  div_cfg_t             shd_q, shd_d;
  logic [DIV_W_DEF-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 running;
  logic                 wrap;
  logic                 commit;

  // Shadow only reaches the active config at a period boundary, a sync or while idle.
  always_comb begin
    running = en && (act_q.div != '0);
    wrap    = running && (cnt_q == act_q.div - DIV_W_DEF'(1));
    commit  = pend_q && (wrap || sync || !running);

    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q + DIV_W_DEF'(1);
    clk_d  = running && (cnt_q < act_q.duty);
    tick_d = wrap;

    if (!running || sync || wrap) begin
      cnt_d = '0;
    end

    if (wr) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end else if (commit) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      act_q  <= '0;
      shd_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clock_divider_bank.sv
// N-channel programmable clock/PWM divider with shadowed config and global sync.
module clock_divider_bank
  import clock_div_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  // Config struct width comes from the package; DIV_W is expected to equal DIV_W_DEF.
  parameter int unsigned DIV_W    = DIV_W_DEF,
  localparam int unsigned CH_W    = ch_width(CHANNELS)
) (
  input  logic                clock_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_duty,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam int unsigned CH_SLOTS = 1 << CH_W;

  logic [CH_SLOTS-1:0] pend_pad;
  logic [CHANNELS-1:0] wr_vec;
  div_cfg_t            wr_cfg;

  // Unused channel slots read as not pending, so out-of-range writes are accepted and dropped.
  assign pend_pad  = CH_SLOTS'(pending);
  assign cfg_ready = ~pend_pad[cfg_ch];
  assign wr_cfg    = '{div: DIV_W_DEF'(cfg_div), duty: DIV_W_DEF'(cfg_duty)};

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    assign wr_vec[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    clock_divider_channel u_ch (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .en       (ch_en[i]),
      .sync     (sync),
      .wr       (wr_vec[i]),
      .wr_cfg   (wr_cfg),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed self-checking bench for clock_divider_bank (6 channels so cfg_ch can go out of range).
module tb_clock_divider_bank;

  localparam int unsigned NCH = 6;

  logic           clock_in = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_ch;
  logic [27:0]    cfg_div;
  logic [27:0]    cfg_duty;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int tests_run    = 0;
  int tests_failed = 0;

  clock_divider_bank #(.CHANNELS(NCH)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .ch_en     (ch_en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_duty  (cfg_duty),
    .clk_out   (clk_out),
    .tick      (tick),
    .pending   (pending)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int d, input int du);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_div   = 28'(d);
    cfg_duty  = 28'(du);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic program_ch(input int ch, input int d, input int du);
    ch_en[ch] = 1'b0;
    cfg_write(ch, d, du);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ch_en = '0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = 3'd0; cfg_div = '0; cfg_duty = '0;
    #2;
    tests_run++;
    if (clk_out !== 6'b0) begin tests_failed++; $display("FAIL reset_clk_out got %b want 000000", clk_out); end
    tests_run++;
    if (tick !== 6'b0) begin tests_failed++; $display("FAIL reset_tick got %b want 000000", tick); end
    tests_run++;
    if (pending !== 6'b0) begin tests_failed++; $display("FAIL reset_pending got %b want 000000", pending); end
    tests_run++;
    if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [9:0] pat_clk;
    logic [9:0] pat_tick;
    pat_clk  = 10'b0001100011;
    pat_tick = 10'b1000010000;
    ch_en[0] = 1'b0;
    cfg_write(0, 5, 2);
    tests_run++;
    if (pending[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_pending_set got %b want 1", pending[0]); end
    tests_run++;
    if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_low got %b want 0", cfg_ready); end
    step();
    tests_run++;
    if (pending[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_commit got %b want 0", pending[0]); end
    ch_en[0] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      tests_run++;
      if (clk_out[0] !== pat_clk[n]) begin tests_failed++; $display("FAIL basic_clk[%0d] got %b want %b", n, clk_out[0], pat_clk[n]); end
      tests_run++;
      if (tick[0] !== pat_tick[n]) begin tests_failed++; $display("FAIL basic_tick[%0d] got %b want %b", n, tick[0], pat_tick[n]); end
    end
  endtask

  task automatic test_reload();
    logic [17:0] exp_clk;
    logic [17:0] exp_tick;
    logic [17:0] exp_pend;
    exp_clk  = 18'b000100010000011111;
    exp_tick = 18'b100010001000000000;
    exp_pend = 18'b000000000111111000;
    ch_en[0] = 1'b0;
    cfg_write(0, 10, 5);
    step();
    ch_en[0] = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      step();
      tests_run++;
      if (clk_out[0] !== exp_clk[n-1]) begin tests_failed++; $display("FAIL reload_clk[%0d] got %b want %b", n, clk_out[0], exp_clk[n-1]); end
      tests_run++;
      if (tick[0] !== exp_tick[n-1]) begin tests_failed++; $display("FAIL reload_tick[%0d] got %b want %b", n, tick[0], exp_tick[n-1]); end
      tests_run++;
      if (pending[0] !== exp_pend[n-1]) begin tests_failed++; $display("FAIL reload_pending[%0d] got %b want %b", n, pending[0], exp_pend[n-1]); end
      if (n == 3) begin
        cfg_ch = 3'd0;
        tests_run++;
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reload_ready_before got %b want 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_div = 28'd4; cfg_duty = 28'd1;
      end else if (n >= 4 && n <= 9) begin
        // Second write is held against a stalled handshake until just before the wrap.
        cfg_div = 28'd7; cfg_duty = 28'd3;
        tests_run++;
        if (cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL reload_stall[%0d] got %b want 0", n, cfg_ready); end
        if (n == 9) cfg_valid = 1'b0;
      end
    end
  endtask

  task automatic test_edges();
    int  divs  [4] = '{0, 1, 6, 6};
    int  duties[4] = '{3, 1, 9, 0};
    logic clk_c[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_t;
    for (int c = 0; c < 4; c++) begin
      program_ch(1, divs[c], duties[c]);
      ch_en[1] = 1'b1;
      for (int n = 1; n <= 12; n++) begin
        step();
        if (divs[c] == 0)      exp_t = 1'b0;
        else if (divs[c] == 1) exp_t = 1'b1;
        else                   exp_t = ((n % 6) == 0);
        tests_run++;
        if (clk_out[1] !== clk_c[c]) begin tests_failed++; $display("FAIL edge%0d_clk[%0d] got %b want %b", c, n, clk_out[1], clk_c[c]); end
        tests_run++;
        if (tick[1] !== exp_t) begin tests_failed++; $display("FAIL edge%0d_tick[%0d] got %b want %b", c, n, tick[1], exp_t); end
      end
    end
  endtask

  task automatic test_sync();
    logic [5:0] c0, t0, c1, t1;
    logic [3:0] w_tick, w_clk;
    c0 = 6'b110011; t0 = 6'b001000;
    c1 = 6'b000111; t1 = 6'b100000;
    w_tick = 4'b1000; w_clk = 4'b0011;
    ch_en = '0;
    program_ch(0, 4, 2);
    program_ch(1, 6, 3);
    ch_en[0] = 1'b1;
    step();
    ch_en[1] = 1'b1;
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    tests_run++;
    if (clk_out[1:0] !== 2'b10 || tick[1:0] !== 2'b00) begin
      tests_failed++; $display("FAIL sync_edge got clk %b tick %b want clk 10 tick 00", clk_out[1:0], tick[1:0]);
    end
    for (int n = 0; n < 6; n++) begin
      step();
      tests_run++;
      if ({clk_out[0], tick[0], clk_out[1], tick[1]} !== {c0[n], t0[n], c1[n], t1[n]}) begin
        tests_failed++;
        $display("FAIL sync_restart[%0d] got %b%b%b%b want %b%b%b%b", n, clk_out[0], tick[0], clk_out[1], tick[1], c0[n], t0[n], c1[n], t1[n]);
      end
    end
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    tests_run++;
    if (tick[0] !== 1'b1) begin tests_failed++; $display("FAIL sync_on_wrap_tick got %b want 1", tick[0]); end
    for (int n = 0; n < 4; n++) begin
      step();
      tests_run++;
      if (tick[0] !== w_tick[n] || clk_out[0] !== w_clk[n]) begin
        tests_failed++; $display("FAIL sync_wrap_after[%0d] got tick %b clk %b want tick %b clk %b", n, tick[0], clk_out[0], w_tick[n], w_clk[n]);
      end
    end
  endtask

  task automatic test_enable_oor();
    logic [2:0] e_clk, e_tick;
    e_clk = 3'b001; e_tick = 3'b100;
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    cfg_write(0, 3, 1);
    tests_run++;
    if (clk_out[0] !== 1'b1 || pending[0] !== 1'b1) begin
      tests_failed++; $display("FAIL en_before_drop got clk %b pend %b want clk 1 pend 1", clk_out[0], pending[0]);
    end
    ch_en[0] = 1'b0;
    step();
    tests_run++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || pending[0] !== 1'b0) begin
      tests_failed++; $display("FAIL en_drop got clk %b tick %b pend %b want 0 0 0", clk_out[0], tick[0], pending[0]);
    end
    ch_en[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      tests_run++;
      if (clk_out[0] !== e_clk[n] || tick[0] !== e_tick[n]) begin
        tests_failed++; $display("FAIL en_new_cfg[%0d] got clk %b tick %b want clk %b tick %b", n, clk_out[0], tick[0], e_clk[n], e_tick[n]);
      end
    end
    cfg_valid = 1'b1; cfg_div = 28'd2; cfg_duty = 28'd1;
    cfg_ch = 3'd6;
    #1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL oor_ready_ch6 got %b want 1", cfg_ready); end
    cfg_ch = 3'd7;
    #1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL oor_ready_ch7 got %b want 1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (pending !== 6'b0) begin tests_failed++; $display("FAIL oor_pending got %b want 000000", pending); end
  endtask

  task automatic test_reset_midrun();
    ch_en = '1;
    cfg_write(1, 5, 5);
    tests_run++;
    if (pending[1] !== 1'b1) begin tests_failed++; $display("FAIL midrun_pending_pre got %b want 1", pending[1]); end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (clk_out !== 6'b0 || tick !== 6'b0 || pending !== 6'b0) begin
      tests_failed++; $display("FAIL midrun_async got clk %b tick %b pend %b want all 0", clk_out, tick, pending);
    end
    tests_run++;
    if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL midrun_ready got %b want 1", cfg_ready); end
    repeat (2) step();
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      tests_run++;
      if (clk_out !== 6'b0 || tick !== 6'b0) begin
        tests_failed++; $display("FAIL midrun_cleared[%0d] got clk %b tick %b want 0", n, clk_out, tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_edges();
    test_sync();
    test_enable_oor();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
